// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX/MEM/WB forwarding and hazard controller.
// Slot addresses are stored at SLOT_AW bits so one record type serves any AW <= SLOT_AW.
package hazard_pkg;

  localparam int SLOT_AW = 8;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXMEM  = 2'b10;
  localparam logic [1:0] FWD_MEMWB  = 2'b01;
  localparam logic [1:0] FWD_WBHOLD = 2'b11;

  typedef struct packed {
    logic               v;
    logic [SLOT_AW-1:0] waddr;
    logic               ld;
  } slot_t;

  localparam slot_t BUBBLE = '{v: 1'b0, waddr: '0, ld: 1'b0};

  function automatic slot_t make_slot(input logic v, input logic [SLOT_AW-1:0] waddr,
                                      input logic ld);
    slot_t s;
    s.v     = v;
    s.waddr = waddr;
    s.ld    = ld;
    return s;
  endfunction

  function automatic logic slot_hit(input slot_t s, input logic [SLOT_AW-1:0] addr);
    return s.v && (s.waddr == addr);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand match against the three in-flight writer slots: picks the youngest
// forwarding source and flags a load-use hazard against the EX slot.
module fwd_src_match
  import hazard_pkg::*;
#(
  parameter int AW        = 4,
  parameter int RF_WT     = 1,
  parameter int ZERO_HARD = 1
) (
  input  logic [AW-1:0] src_addr,
  input  logic          src_used,
  input  slot_t         ex_slot,
  input  slot_t         mem_slot,
  input  slot_t         wb_slot,
  output logic [1:0]    sel,
  output logic          load_use
);

  logic               live;
  logic               ex_hit;
  logic               mem_hit;
  logic               wb_hit;
  logic [SLOT_AW-1:0] addr_w;
  logic               unused_ld;

  assign addr_w  = SLOT_AW'(src_addr);
  assign live    = src_used && ((ZERO_HARD == 0) || (src_addr != '0));
  assign ex_hit  = live && slot_hit(ex_slot, addr_w);
  assign mem_hit = live && slot_hit(mem_slot, addr_w);
  assign wb_hit  = live && slot_hit(wb_slot, addr_w);

  // A load in EX has no data yet; it falls through here and the stall covers it.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit && !ex_slot.ld) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else if ((RF_WT == 0) && wb_hit) begin
      sel = FWD_WBHOLD;
    end
  end

  assign load_use  = ex_hit && ex_slot.ld;
  assign unused_ld = mem_slot.ld ^ wb_slot.ld;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Forwarding/hazard controller: shadows in-flight writers, registers the EX operand
// selects, raises the load-use stall and counts stall cycles.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int AW        = 4,
  parameter int NSRC      = 3,
  parameter int RF_WT     = 1,
  parameter int ZERO_HARD = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [NSRC*AW-1:0]  id_src_addr,
  input  logic [NSRC-1:0]     id_src_used,
  input  logic                id_wen,
  input  logic [AW-1:0]       id_waddr,
  input  logic                id_is_load,
  input  logic                flush,
  input  logic                pipe_hold,
  output logic                stall,
  output logic [2*NSRC-1:0]   fwd_sel,
  output logic [CNT_W-1:0]    stall_cnt
);

  slot_t             ex_q;
  slot_t             mem_q;
  slot_t             wb_q;
  slot_t             id_rec;
  logic [NSRC-1:0]   load_use;
  logic [2*NSRC-1:0] sel_next;

  assign id_rec = make_slot(id_valid & id_wen, SLOT_AW'(id_waddr), id_is_load);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(
      .AW       (AW),
      .RF_WT    (RF_WT),
      .ZERO_HARD(ZERO_HARD)
    ) u_match (
      .src_addr(id_src_addr[i*AW +: AW]),
      .src_used(id_valid & id_src_used[i]),
      .ex_slot (ex_q),
      .mem_slot(mem_q),
      .wb_slot (wb_q),
      .sel     (sel_next[2*i +: 2]),
      .load_use(load_use[i])
    );
  end

  assign stall = (|load_use) & ~flush;

  // A stall keeps the consumer in ID and lets the load advance into MEM, so the
  // retry one cycle later picks it up through the MEM/WB path.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= BUBBLE;
      mem_q     <= BUBBLE;
      wb_q      <= BUBBLE;
      fwd_sel   <= '0;
      stall_cnt <= '0;
    end else if (pipe_hold) begin
      ex_q      <= ex_q;
      mem_q     <= mem_q;
      wb_q      <= wb_q;
      fwd_sel   <= fwd_sel;
      stall_cnt <= stall_cnt;
    end else if (flush) begin
      ex_q      <= BUBBLE;
      mem_q     <= BUBBLE;
      wb_q      <= mem_q;
      fwd_sel   <= '0;
    end else if (stall) begin
      ex_q      <= BUBBLE;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_sel   <= '0;
      if (stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      ex_q      <= id_rec;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_sel   <= sel_next;
    end
  end

endmodule
